// File: rtl/fifo_sync_controller.sv
// Synchronous FIFO controller: owns the write/read pointers of an external
// dual-port RAM, and produces the RAM strobes, addresses, occupancy, status
// flags, Gray-coded pointers and sticky error flags. No data passes through it.
//
// Handshake: wr_enable / rd_enable are requests. A request is accepted in the
// cycle it is presented only if the FIFO can honour it (write: not full,
// read: not empty). The acceptance is the strobe itself (mem_wr_en / mem_rd_en).
// A rejected request is dropped, not queued, and sets the matching sticky
// error flag. Read data from the RAM is valid one cycle after mem_rd_en, which
// rd_valid marks.
module fifo_sync_controller #(
    parameter int depth     = 8,
    parameter int af_margin = 2,
    parameter int ae_margin = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_enable,
    input  logic             rd_enable,
    output logic             mem_wr_en,
    output logic [depth-1:0] mem_wr_address,
    output logic             mem_rd_en,
    output logic [depth-1:0] mem_rd_address,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [depth:0]   count,
    output logic [depth:0]   wr_gray,
    output logic [depth:0]   rd_gray,
    output logic             overflow,
    output logic             underflow
);

    localparam int             capacity   = 1 << depth;
    localparam logic [depth:0] full_level = (depth + 1)'(capacity);
    localparam logic [depth:0] af_level   = (depth + 1)'(capacity - af_margin);
    localparam logic [depth:0] ae_level   = (depth + 1)'(ae_margin);

    // Pointers carry one extra wrap bit so that full and empty are
    // distinguishable; the RAM only sees the low depth bits.
    logic [depth:0] wr_ptr;
    logic [depth:0] rd_ptr;
    logic [depth:0] count_next;

    // Accept requests only when the registered flags allow them; a write
    // into a full FIFO is refused even if a read drains an entry this cycle.
    always_comb begin
        mem_wr_en      = wr_enable & ~full;
        mem_rd_en      = rd_enable & ~empty;
        mem_wr_address = wr_ptr[depth-1:0];
        mem_rd_address = rd_ptr[depth-1:0];
    end

    // Occupancy after this edge; the flags are derived from it so they are
    // correct in the cycle that follows the causing edge.
    always_comb begin
        count_next = count
                   + {{depth{1'b0}}, mem_wr_en}
                   - {{depth{1'b0}}, mem_rd_en};
    end

    // Gray-coded views of the full-width pointers.
    always_comb begin
        wr_gray = wr_ptr ^ (wr_ptr >> 1);
        rd_gray = rd_ptr ^ (rd_ptr >> 1);
    end

    // Pointer advance on each accepted strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (mem_wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (mem_rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy counter and status flags, all registered from count_next.
    always_ff @(posedge clock) begin
        if (reset) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= count_next;
            full         <= (count_next == full_level);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= af_level);
            almost_empty <= (count_next <= ae_level);
        end
    end

    // RAM read data arrives one cycle after the accepted read strobe.
    always_ff @(posedge clock) begin
        if (reset) rd_valid <= 1'b0;
        else       rd_valid <= mem_rd_en;
    end

    // Sticky error flags: any refused request is remembered until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_enable && full)  overflow  <= 1'b1;
            if (rd_enable && empty) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_sync_controller.sv
// Bench for fifo_sync_controller at depth=3. A behavioural FIFO model (a data
// queue plus running write/read totals) predicts every per-cycle output; a
// small RAM in the bench carries real data so read ordering is checked end to
// end whenever rd_valid is presented.
module tb_fifo_sync_controller;

  localparam int DEPTH = 3;
  localparam int AF    = 2;
  localparam int AE    = 2;
  localparam int CAP   = 1 << DEPTH;

  typedef struct packed {
    logic             we;
    logic             re;
    logic [DEPTH-1:0] wa;
    logic [DEPTH-1:0] ra;
    logic [DEPTH:0]   cnt;
    logic             full;
    logic             empty;
    logic             af;
    logic             ae;
    logic [DEPTH:0]   wg;
    logic [DEPTH:0]   rg;
    logic             ovf;
    logic             udf;
    logic             rv;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  logic             clock = 1'b0;
  logic             reset;
  logic             wr_enable;
  logic             rd_enable;
  logic             mem_wr_en;
  logic [DEPTH-1:0] mem_wr_address;
  logic             mem_rd_en;
  logic [DEPTH-1:0] mem_rd_address;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [DEPTH:0]   count;
  logic [DEPTH:0]   wr_gray;
  logic [DEPTH:0]   rd_gray;
  logic             overflow;
  logic             underflow;

  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [7:0] tb_ram [0:CAP-1];

  logic [EXP_W-1:0] exp_q[$];
  logic [7:0]       rd_exp_q[$];

  // reference model state
  logic [7:0] model_q[$];
  int         wr_total;
  int         rd_total;
  bit         m_ovf;
  bit         m_udf;
  bit         m_rv;
  bit         known;

  int n_checks = 0;
  int n_pass   = 0;

  fifo_sync_controller #(
    .depth     (DEPTH),
    .af_margin (AF),
    .ae_margin (AE)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_enable      (wr_enable),
    .rd_enable      (rd_enable),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_address (mem_wr_address),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_address (mem_rd_address),
    .rd_valid       (rd_valid),
    .full           (full),
    .empty          (empty),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .count          (count),
    .wr_gray        (wr_gray),
    .rd_gray        (rd_gray),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  // clock / reset
  always #5 clock = ~clock;

  // dual-port RAM driven by the DUT's strobes and addresses
  always @(posedge clock) begin
    if (mem_wr_en) tb_ram[mem_wr_address] <= wr_data;
    if (mem_rd_en) rd_data <= tb_ram[mem_rd_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // driver: one cycle of stimulus, predict this cycle's outputs, advance model
  task automatic drive_cycle(input bit rst, input bit wr, input bit rd);
    exp_t e;
    int   occ;
    int   wp;
    int   rp;
    @(negedge clock);
    reset     = rst;
    wr_enable = wr;
    rd_enable = rd;
    wr_data   = 8'($urandom);
    occ = model_q.size();
    e = '0;
    if (known) begin
      e.full  = (occ == CAP);
      e.empty = (occ == 0);
      e.we    = wr && (occ != CAP);
      e.re    = rd && (occ != 0);
      e.wa    = DEPTH'(wr_total % CAP);
      e.ra    = DEPTH'(rd_total % CAP);
      e.cnt   = (DEPTH + 1)'(occ);
      e.af    = (occ >= CAP - AF);
      e.ae    = (occ <= AE);
      wp      = wr_total % (2 * CAP);
      rp      = rd_total % (2 * CAP);
      e.wg    = (DEPTH + 1)'(wp ^ (wp >> 1));
      e.rg    = (DEPTH + 1)'(rp ^ (rp >> 1));
      e.ovf   = m_ovf;
      e.udf   = m_udf;
      e.rv    = m_rv;
      exp_q.push_back(EXP_W'(e));
    end
    if (rst) begin
      model_q.delete();
      wr_total = 0;
      rd_total = 0;
      m_ovf    = 0;
      m_udf    = 0;
      m_rv     = 0;
      known    = 1;
    end else if (known) begin
      if (wr && occ == CAP) m_ovf = 1;
      if (rd && occ == 0)   m_udf = 1;
      m_rv = e.re;
      if (e.re) begin
        rd_exp_q.push_back(model_q.pop_front());
        rd_total++;
      end
      if (e.we) begin
        model_q.push_back(wr_data);
        wr_total++;
      end
    end
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    logic [7:0] d;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_t'(exp_q.pop_front());
        check("mem_wr_en",      32'(mem_wr_en),      32'(e.we));
        check("mem_rd_en",      32'(mem_rd_en),      32'(e.re));
        check("mem_wr_address", 32'(mem_wr_address), 32'(e.wa));
        check("mem_rd_address", 32'(mem_rd_address), 32'(e.ra));
        check("count",          32'(count),          32'(e.cnt));
        check("full",           32'(full),           32'(e.full));
        check("empty",          32'(empty),          32'(e.empty));
        check("almost_full",    32'(almost_full),    32'(e.af));
        check("almost_empty",   32'(almost_empty),   32'(e.ae));
        check("wr_gray",        32'(wr_gray),        32'(e.wg));
        check("rd_gray",        32'(rd_gray),        32'(e.rg));
        check("overflow",       32'(overflow),       32'(e.ovf));
        check("underflow",      32'(underflow),      32'(e.udf));
        check("rd_valid",       32'(rd_valid),       32'(e.rv));
      end
      if (rd_valid === 1'b1) begin
        if (rd_exp_q.size() == 0) begin
          check("rd_data_expected", 32'(0), 32'(1));
        end else begin
          d = rd_exp_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(d));
        end
      end
    end
  end

  // stimulus
  initial begin
    int pw;
    int pr;
    reset     = 1'b1;
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    wr_data   = '0;
    wr_total  = 0;
    rd_total  = 0;
    m_ovf     = 0;
    m_udf     = 0;
    m_rv      = 0;
    known     = 0;

    drive_cycle(1, 0, 0);
    drive_cycle(1, 0, 0);
    // fill to full
    for (int i = 0; i < CAP; i++) drive_cycle(0, 1, 0);
    // full with both requests, then observe
    drive_cycle(0, 1, 1);
    drive_cycle(0, 0, 0);
    // empty with both requests
    drive_cycle(1, 0, 0);
    drive_cycle(0, 1, 1);
    drive_cycle(0, 0, 0);
    drive_cycle(0, 0, 0);
    // steady streaming at count 4
    drive_cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) drive_cycle(0, 1, 0);
    for (int i = 0; i < 20; i++) drive_cycle(0, 1, 1);
    drive_cycle(0, 0, 0);
    // reset mid-operation at count 5 with a write pending
    drive_cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) drive_cycle(0, 1, 0);
    drive_cycle(1, 1, 0);
    drive_cycle(0, 0, 0);
    drive_cycle(0, 0, 1);

    // randomized traffic with changing write/read bias
    pw = 50;
    pr = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 500 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      drive_cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 99) < pw,
                  $urandom_range(0, 99) < pr);
    end

    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 0);
    @(negedge clock);
    #5;
    check("exp_q_drained",    32'(exp_q.size()),    32'(0));
    check("rd_exp_q_drained", 32'(rd_exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_controller.md
FIFO_SYNC_CONTROLLER -- requirements
Module: fifo_sync_controller

Interface
REQ-001 Parameter: depth, default 8, address width in bits; FIFO capacity = 2^depth entries.
REQ-002 Parameter: af_margin, default 2, almost_full asserted when count >= 2^depth - af_margin.
REQ-003 Parameter: ae_margin, default 2, almost_empty asserted when count <= ae_margin.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_enable  input  1  write request from producer.
REQ-007 rd_enable  input  1  read request from consumer.
REQ-008 mem_wr_en  output  1  qualified write strobe to dual-port RAM.
REQ-009 mem_wr_address  output  depth  RAM write address.
REQ-010 mem_rd_en  output  1  qualified read strobe to RAM.
REQ-011 mem_rd_address  output  depth  RAM read address.
REQ-012 rd_valid  output  1  RAM read data valid (one cycle after mem_rd_en).
REQ-013 full, empty, almost_full, almost_empty  output  1 each  registered status flags.
REQ-014 count  output  depth+1  registered occupancy, 0 to 2^depth.
REQ-015 wr_gray, rd_gray  output  depth+1  Gray-coded pointers, g = p ^ (p >> 1).
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Internal write and read pointers SHALL be depth+1 bits wide, wrap modulo 2^(depth+1); RAM addresses are the low depth bits.
REQ-018 mem_wr_en = wr_enable & ~full, combinational; write pointer increments by 1 at edge when mem_wr_en.
REQ-019 mem_rd_en = rd_enable & ~empty, combinational; read pointer increments by 1 at edge when mem_rd_en.
REQ-020 mem_wr_address and mem_rd_address SHALL be the current (pre-increment) pointer low bits, combinational from the pointer registers.
REQ-021 rd_valid SHALL be a register loaded with mem_rd_en each cycle (latency 1).
REQ-022 count next = count + mem_wr_en - mem_rd_en; both accepted in the same cycle -> count unchanged.
REQ-023 Flags SHALL be registered, computed from next count: full = (next = 2^depth), empty = (next = 0), almost_full/almost_empty per REQ-002/003; flags valid the cycle after the causing edge.
REQ-024 Write while full SHALL be rejected even if a read is accepted in the same cycle; read while empty SHALL be rejected even if a write is accepted in the same cycle.
REQ-025 overflow set when wr_enable & full; underflow set when rd_enable & empty; both hold until reset.
REQ-026 wr_gray/rd_gray SHALL be combinational from the full depth+1-bit pointers.
REQ-027 Invariant: count = (wr_ptr - rd_ptr) mod 2^(depth+1) at all times.

Reset
REQ-028 On reset high at a rising edge: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, rd_valid 0, overflow 0, underflow 0.
REQ-029 Reset SHALL take priority over wr_enable/rd_enable in the same cycle; mid-operation reset discards all content.
REQ-030 During reset, mem_wr_en and mem_rd_en follow REQ-018/019 from the reset-state flags; no RAM data is retained.

Verification (depth=3, af_margin=2, ae_margin=2)
REQ-031 Reset, then 8 writes -> mem_wr_address 0..7, count 8, full 1, almost_full 1 from count 6, empty 0 after first write.
REQ-032 Full, wr_enable and rd_enable both high -> mem_wr_en 0, mem_rd_en 1, count 7, full 0, overflow 1.
REQ-033 Empty, wr_enable and rd_enable both high -> mem_rd_en 0, count 1, empty 0, underflow 1, rd_valid 0 next cycle.
REQ-034 20 cycles simultaneous read/write at count 4 -> count stays 4, addresses wrap 7->0, wr_gray-rd_gray distance constant, rd_valid 1 each cycle after first.
REQ-035 Reset asserted at count 5 with wr_enable high -> next cycle count 0, empty 1, pointers 0, overflow/underflow 0.
REQ-036 Random wr/rd stimulus 10k cycles -> REQ-027 invariant holds and flags match a reference occupancy model every cycle.
